// File: rtl/clkgen_multi.sv
`default_nettype none
// ============================================================================
// Module   : clkgen_multi
// Purpose  : Multi-channel integer clock divider with settle/lock sequencing
//            and per-channel reset release timed on each channel's own
//            rising edges.
// Revision : 1.0 - initial release
// ============================================================================
module clkgen_multi #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 16,
    parameter int RST_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    en,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic                    div_load,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       ch_rstn,
    output logic                    locked,
    output logic                    busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETTLE = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;

    localparam int                 c_SET_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(LOCK_CYCLES - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_SET_W-1:0] r_settle_cnt;
    logic               r_locked;
    logic               r_busy;
    logic               w_restart;
    logic               w_run;
    logic               w_keep_locked;

    // Restart requests, next-state selection and per-edge qualifiers.
    always_comb begin
        w_restart     = en && ((r_state == c_IDLE) || div_load);
        w_state_nxt   = r_state;
        if (!en) begin
            w_state_nxt = c_IDLE;
        end else if (w_restart) begin
            w_state_nxt = c_SETTLE;
        end else if ((r_state == c_SETTLE) && (r_settle_cnt == c_SET_LAST)) begin
            w_state_nxt = c_LOCKED;
        end else if ((r_state != c_SETTLE) && (r_state != c_LOCKED)) begin
            w_state_nxt = c_IDLE;
        end
        // Dividers advance only while enabled in SETTLE or LOCKED.
        w_run         = en && ((r_state == c_SETTLE) || (r_state == c_LOCKED));
        // Reset sequencing advances only on edges that stay in LOCKED.
        w_keep_locked = (r_state == c_LOCKED) && (w_state_nxt == c_LOCKED);
    end

    // State register plus registered lock/busy flags tracking the new state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= c_IDLE;
            r_locked <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_locked <= (w_state_nxt == c_LOCKED);
            r_busy   <= (w_state_nxt == c_SETTLE);
        end
    end

    // Settle counter: cleared on restart or outside SETTLE, counts otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_settle_cnt <= '0;
        end else if (w_restart || (w_state_nxt != c_SETTLE)) begin
            r_settle_cnt <= '0;
        end else begin
            r_settle_cnt <= r_settle_cnt + c_SET_W'(1);
        end
    end

    assign locked = r_locked;
    assign busy   = r_busy;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [DIV_W-1:0]      r_ratio;
            logic [DIV_W-1:0]      r_cnt;
            logic                  r_out;
            logic [RST_STAGES-1:0] r_sh;
            logic [DIV_W-1:0]      w_d;
            logic [DIV_W-1:0]      w_h;
            logic [DIV_W-1:0]      w_cnt_nxt;
            logic                  w_wrap;
            logic                  w_rise;

            // Effective ratio (0/1 clamp to 2), high time and next count.
            always_comb begin
                w_d       = (r_ratio < DIV_W'(2)) ? DIV_W'(2) : r_ratio;
                w_h       = (w_d >> 1) + {{(DIV_W-1){1'b0}}, w_d[0]};
                w_wrap    = (r_cnt == (w_d - DIV_W'(1)));
                w_cnt_nxt = w_wrap ? '0 : (r_cnt + DIV_W'(1));
                w_rise    = w_run && w_wrap;
            end

            // Ratio register: latched on any div_load strobe, any state.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_ratio <= DIV_W'(DEFAULT_DIV);
                end else if (div_load) begin
                    r_ratio <= div_ratio[i*DIV_W +: DIV_W];
                end
            end

            // Divider: restart forces phase zero high; idle holds everything low.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_cnt <= '0;
                    r_out <= 1'b0;
                end else if (w_restart) begin
                    r_cnt <= '0;
                    r_out <= 1'b1;
                end else if (w_run) begin
                    r_cnt <= w_cnt_nxt;
                    r_out <= (w_cnt_nxt < w_h);
                end else begin
                    r_cnt <= '0;
                    r_out <= 1'b0;
                end
            end

            // Reset release shifter: ones enter on rise events while locked.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_sh <= '0;
                end else if (!w_keep_locked) begin
                    r_sh <= '0;
                end else if (w_rise) begin
                    r_sh <= (r_sh << 1) | RST_STAGES'(1);
                end
            end

            assign clk_out[i] = r_out;
            assign ch_rstn[i] = r_sh[RST_STAGES-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/clkgen_multi.md
Name: clkgen_multi

Overview:
- Synthesizable, parametrised multi-channel clock generator with lock indication and per-channel reset release; successor to the behavioural single-clock PLL model.
- Derives NUM_CH divided clocks from clk with runtime-programmable integer ratios.
- Runs a settle/lock state machine and releases one reset per channel, sequenced on that channel's own rising edges.
- Sits at the top of the SoC clock/reset tree, feeding core, bus and peripheral domains.

Parameters:
- NUM_CH, 2, number of output clock channels (1..8).
- DIV_W, 8, width of each divide ratio.
- DEFAULT_DIV, 2, ratio loaded into every channel at reset.
- LOCK_CYCLES, 16, clk cycles spent in SETTLE before locked asserts (>=1).
- RST_STAGES, 2, channel rising edges after lock before that channel's reset releases (>=1).

Ports:
- clk  in  1  reference clock.
- resetn  in  1  reset.
- en  in  1  generator enable.
- div_ratio  in  NUM_CH*DIV_W  ratio for channel i in bits [i*DIV_W +: DIV_W].
- div_load  in  1  one-cycle strobe; latch div_ratio and re-sequence.
- clk_out  out  NUM_CH  divided clocks, registered.
- ch_rstn  out  NUM_CH  per-channel active-low resets, registered.
- locked  out  1  generator locked, registered.
- busy  out  1  high while in SETTLE.

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is clk. While resetn=0: state=IDLE; clk_out=0, ch_rstn=0, locked=0, busy=0; ratio regs=DEFAULT_DIV; counters=0. Reset mid-operation aborts immediately to these values.
- Ratio rule: effective D_i = max(latched ratio_i, 2). Values 0 and 1 are clamped to 2. H_i = ceil(D_i/2).
- div_load: latches div_ratio into the ratio regs on that edge, in any state, including when en=0.
- State machine, with transitions on clk edges:
  - IDLE: all counters held at 0; clk_out=0. en=1 moves to SETTLE and triggers a restart.
  - SETTLE: settle counter starts at 0 and increments each cycle. At count==LOCK_CYCLES-1 the next state is LOCKED. div_load in SETTLE triggers a restart and clears the settle counter.
  - LOCKED: div_load triggers a restart and moves to SETTLE.
  - en=0 in any state moves to IDLE next edge. en=0 has priority over div_load.
- Lock timing: locked=(state==LOCKED) and busy=(state==SETTLE), both registered. Counting the SETTLE-entry edge as edge 0, locked first reads 1 after edge LOCK_CYCLES.
- Restart edge: every channel sets cnt_i=0 and clk_out_i=1 on the same edge. All channels are therefore phase-aligned.
- Divider: after a restart, cnt_i increments mod D_i each edge. clk_out_i is high for H_i cycles, then low for D_i-H_i cycles, repeating. Dividers run in SETTLE and LOCKED.
- Channel rise event: an edge where cnt_i wraps from D_i-1 to 0, making clk_out_i go 0->1. The restart edge itself is not a rise event.
- ch_rstn_i:
  - Driven by an RST_STAGES-deep shift register, cleared on any cycle where the state is not LOCKED.
  - In LOCKED, each rise event shifts in 1; ch_rstn_i is the last stage.
  - Leaving LOCKED (div_load or en=0) drives all ch_rstn to 0 on the next edge.
- Ratios take effect only at a restart. A div_load while en=0 takes effect at the next IDLE->SETTLE.

Test Plan:
- Defaults (NUM_CH=2, LOCK_CYCLES=16, RST_STAGES=2), resetn released, en=1 on edge E:
  - busy=1 from E; locked=1 from E+16.
  - clk_out[0] toggles every cycle from E.
  - ch_rstn both rise 2 rise events after lock, at E+20.
- Load ratios {ch1=5, ch0=3} while LOCKED:
  - locked, busy and ch_rstn drop next edge.
  - ch0 pattern is 1,1,0; ch1 pattern is 1,1,1,0,0; both restart high on the same edge.
  - locked returns 16 edges later; ch1 releases after 2 ch1 rise events.
- Ratios 0 and 1 -> both channels divide by 2, identical to ratio 2.
- div_load repeated every 10 cycles during SETTLE -> locked never asserts; after the strobes stop, locked asserts 16 edges after the last load.
- en=0 while LOCKED -> next edge: IDLE, clk_out=0, locked=0, ch_rstn=0. en=0 plus div_load on the same edge -> IDLE, ratios still latched.
- resetn=0 asynchronously mid-SETTLE (between edges) -> all outputs 0 immediately; ratio regs return to DEFAULT_DIV.
